// File: rtl/ballot_pkg.sv
// Shared types and helpers for the ballot controller: FSM states, status-flag
// bit positions and a saturating increment used by the tallies.
package ballot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AUTH = 2'd1,
        ST_VOTE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int FLAG_VOTE_DONE     = 0;
    localparam int FLAG_INVALID_LOGIN = 1;
    localparam int FLAG_ALREADY_VOTED = 2;
    localparam int FLAG_LOCKED_OUT    = 3;
    localparam int FLAG_TIMEOUT       = 4;
    localparam int NUM_FLAGS          = 5;

    // Increments value, holding at the all-ones value of a width-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/ballot_voter_table.sv
// Per-voter state: programmed password, pw_valid, voted and failed-login count,
// with an admin write port and a combinational lookup by voter id.
module ballot_voter_table
    import ballot_pkg::*;
#(
    parameter int NUM_VOTERS = 8,
    parameter int PW_W       = 8,
    parameter int MAX_TRIES  = 3,
    parameter int VID_W      = 3,
    parameter int TRY_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [VID_W-1:0] i_wr_id,
    input  logic [PW_W-1:0]  i_wr_data,
    input  logic [VID_W-1:0] i_lk_id,
    input  logic [PW_W-1:0]  i_lk_pw,
    input  logic             i_fail_inc,
    input  logic             i_clear_tries,
    input  logic             i_set_voted,
    input  logic [VID_W-1:0] i_mark_id,
    output logic             o_match,
    output logic             o_voted,
    output logic             o_locked,
    output logic             o_last_try
);

    logic [PW_W-1:0]       r_pw [NUM_VOTERS];
    logic [NUM_VOTERS-1:0] r_pw_valid;
    logic [NUM_VOTERS-1:0] r_voted;
    logic [TRY_W-1:0]      r_tries [NUM_VOTERS];

    // Password storage is only meaningful once pw_valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_pw[i_wr_id] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pw_valid <= '0;
            r_voted    <= '0;
            for (int i = 0; i < NUM_VOTERS; i++) begin
                r_tries[i] <= '0;
            end
        end else begin
            if (i_wr_en) begin
                r_pw_valid[i_wr_id] <= 1'b1;
                r_tries[i_wr_id]    <= '0;
            end else if (i_fail_inc) begin
                if (r_tries[i_lk_id] != TRY_W'(MAX_TRIES)) begin
                    r_tries[i_lk_id] <= r_tries[i_lk_id] + TRY_W'(1);
                end
            end else if (i_clear_tries) begin
                r_tries[i_lk_id] <= '0;
            end
            if (i_set_voted) begin
                r_voted[i_mark_id] <= 1'b1;
            end
        end
    end

    assign o_match    = r_pw_valid[i_lk_id] && (r_pw[i_lk_id] == i_lk_pw);
    assign o_voted    = r_voted[i_lk_id];
    assign o_locked   = (r_tries[i_lk_id] == TRY_W'(MAX_TRIES));
    assign o_last_try = (r_tries[i_lk_id] == TRY_W'(MAX_TRIES - 1));

endmodule

// File: rtl/ballot_controller.sv
// Voting session FSM: authenticates a voter, records one vote into saturating
// tallies, enforces lockout and vote timeout, and exposes a readout port.
module ballot_controller
    import ballot_pkg::*;
#(
    parameter int NUM_VOTERS   = 8,
    parameter int NUM_CANDS    = 4,
    parameter int CNT_W        = 8,
    parameter int PW_W         = 8,
    parameter int MAX_TRIES    = 3,
    parameter int VOTE_TIMEOUT = 255,
    localparam int VID_W       = $clog2(NUM_VOTERS),
    localparam int CID_W       = (NUM_CANDS > 2) ? $clog2(NUM_CANDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             poll_open,
    input  logic             start,
    input  logic             submit,
    input  logic [VID_W-1:0] voter_id,
    input  logic [PW_W-1:0]  password,
    input  logic [CID_W-1:0] vote,
    input  logic             pw_wr_en,
    input  logic [VID_W-1:0] pw_wr_id,
    input  logic [PW_W-1:0]  pw_wr_data,
    input  logic [CID_W-1:0] rd_cand,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] total_votes,
    output logic             busy,
    output logic             vote_done,
    output logic             invalid_login,
    output logic             already_voted,
    output logic             locked_out,
    output logic             timeout,
    output logic             invalid_vote
);

    localparam int TMR_W = $clog2(VOTE_TIMEOUT + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [NUM_FLAGS-1:0] r_flags;
    logic [NUM_FLAGS-1:0] w_flags_next;
    logic                 r_inv_vote;
    logic                 w_inv_vote_next;
    logic [TMR_W-1:0]     r_timer;
    logic [TMR_W-1:0]     w_timer_next;
    logic [TMR_W-1:0]     w_timer_inc;
    logic [VID_W-1:0]     r_vid;
    logic [CNT_W-1:0]     r_tally [NUM_CANDS];
    logic [CNT_W-1:0]     w_tally_next [NUM_CANDS];
    logic [31:0]          w_tally_sat [NUM_CANDS];
    logic [CNT_W-1:0]     r_total;
    logic [31:0]          w_total_sat;
    logic [CNT_W-1:0]     w_rd_count;

    logic w_pw_wr;
    logic w_vote_ok;
    logic w_fail_inc;
    logic w_clear_tries;
    logic w_set_voted;
    logic w_count_vote;
    logic w_lk_match;
    logic w_lk_voted;
    logic w_lk_locked;
    logic w_lk_last_try;

    // Table may only be reprogrammed while the poll is closed and no session is active.
    assign w_pw_wr   = pw_wr_en && !poll_open && (r_state == ST_IDLE);
    assign w_vote_ok = (32'(vote) < 32'(NUM_CANDS));

    ballot_voter_table #(
        .NUM_VOTERS (NUM_VOTERS),
        .PW_W       (PW_W),
        .MAX_TRIES  (MAX_TRIES),
        .VID_W      (VID_W),
        .TRY_W      (TRY_W)
    ) u_voter_table (
        .clk           (clk),
        .rst           (rst),
        .i_wr_en       (w_pw_wr),
        .i_wr_id       (pw_wr_id),
        .i_wr_data     (pw_wr_data),
        .i_lk_id       (voter_id),
        .i_lk_pw       (password),
        .i_fail_inc    (w_fail_inc),
        .i_clear_tries (w_clear_tries),
        .i_set_voted   (w_set_voted),
        .i_mark_id     (r_vid),
        .o_match       (w_lk_match),
        .o_voted       (w_lk_voted),
        .o_locked      (w_lk_locked),
        .o_last_try    (w_lk_last_try)
    );

    always_comb begin
        w_state_next    = r_state;
        w_flags_next    = r_flags;
        w_inv_vote_next = 1'b0;
        w_timer_inc     = r_timer + TMR_W'(1);
        w_timer_next    = r_timer;
        w_fail_inc      = 1'b0;
        w_clear_tries   = 1'b0;
        w_set_voted     = 1'b0;
        w_count_vote    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_flags_next = '0;
                if (start && poll_open) begin
                    w_state_next = ST_AUTH;
                end
            end
            ST_AUTH: begin
                w_state_next = ST_DONE;
                if (w_lk_locked) begin
                    w_flags_next[FLAG_LOCKED_OUT] = 1'b1;
                end else if (!w_lk_match) begin
                    w_flags_next[FLAG_INVALID_LOGIN] = 1'b1;
                    w_fail_inc = 1'b1;
                    if (w_lk_last_try) begin
                        w_flags_next[FLAG_LOCKED_OUT] = 1'b1;
                    end
                end else if (w_lk_voted) begin
                    w_flags_next[FLAG_ALREADY_VOTED] = 1'b1;
                end else begin
                    w_clear_tries = 1'b1;
                    w_timer_next  = '0;
                    w_state_next  = ST_VOTE;
                end
            end
            ST_VOTE: begin
                w_timer_next = w_timer_inc;
                // A valid submit takes precedence over a simultaneous timer expiry.
                if (submit && w_vote_ok) begin
                    w_count_vote = 1'b1;
                    w_set_voted  = 1'b1;
                    w_flags_next[FLAG_VOTE_DONE] = 1'b1;
                    w_state_next = ST_DONE;
                end else if (w_timer_inc == TMR_W'(VOTE_TIMEOUT)) begin
                    w_flags_next[FLAG_TIMEOUT] = 1'b1;
                    w_state_next = ST_DONE;
                end else if (submit) begin
                    w_inv_vote_next = 1'b1;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_flags    <= '0;
            r_inv_vote <= 1'b0;
            r_timer    <= '0;
            r_vid      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_flags    <= w_flags_next;
            r_inv_vote <= w_inv_vote_next;
            r_timer    <= w_timer_next;
            if (r_state == ST_AUTH) begin
                r_vid <= voter_id;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CANDS; c++) begin
            w_tally_sat[c]  = sat_inc(32'(r_tally[c]), CNT_W);
            w_tally_next[c] = w_tally_sat[c][CNT_W-1:0];
        end
        w_total_sat = sat_inc(32'(r_total), CNT_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_total <= '0;
            for (int c = 0; c < NUM_CANDS; c++) begin
                r_tally[c] <= '0;
            end
        end else if (w_count_vote) begin
            r_total <= w_total_sat[CNT_W-1:0];
            for (int c = 0; c < NUM_CANDS; c++) begin
                if (vote == CID_W'(c)) begin
                    r_tally[c] <= w_tally_next[c];
                end
            end
        end
    end

    // Readout is hidden while the poll is open so partial results never leak.
    always_comb begin
        w_rd_count = '0;
        for (int c = 0; c < NUM_CANDS; c++) begin
            if (!poll_open && (rd_cand == CID_W'(c))) begin
                w_rd_count = r_tally[c];
            end
        end
    end

    assign rd_count      = w_rd_count;
    assign total_votes   = r_total;
    assign busy          = (r_state != ST_IDLE);
    assign vote_done     = r_flags[FLAG_VOTE_DONE];
    assign invalid_login = r_flags[FLAG_INVALID_LOGIN];
    assign already_voted = r_flags[FLAG_ALREADY_VOTED];
    assign locked_out    = r_flags[FLAG_LOCKED_OUT];
    assign timeout       = r_flags[FLAG_TIMEOUT];
    assign invalid_vote  = r_inv_vote;

endmodule
